// File: rtl/sha256_bytes_feed.sv
// Byte-stream sequencer for the sha256 realign/pad stage: reads words, emits data, pad and length beats.
// Optional request/overflow checking is built when SHA256_FEED_ERR_CHK_EN is defined.
module sha256_bytes_feed #(
  parameter int ADDR_MSB  = 7,
  parameter int TOTAL_MSB = 11
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                start,
  input  logic [ADDR_MSB+2:0] start_addr,
  input  logic [4:0]          byte_cnt,
  input  logic                new_ctx,
  input  logic                finish,
  input  logic                stall,
  output logic                ready,
  output logic                mem_rd_en,
  output logic [ADDR_MSB:0]   mem_rd_addr,
  output logic                wr_en,
  output logic [2:0]          len,
  output logic [1:0]          off,
  output logic                add0x80pad,
  output logic                add0pad,
  output logic                add_total,
  output logic [TOTAL_MSB:0]  total,
  output logic                block_done,
  output logic                err
);

  localparam int AW = ADDR_MSB + 3;
  localparam int TW = TOTAL_MSB + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_PAD80 = 3'd2;
  localparam logic [2:0] S_PADZ  = 3'd3;
  localparam logic [2:0] S_LENHI = 3'd4;
  localparam logic [2:0] S_LENLO = 3'd5;

  logic [2:0]          r_state;
  logic [ADDR_MSB+2:0] r_addr;
  logic [4:0]          r_rem;
  logic                r_first;
  logic                r_finish;
  logic [5:0]          r_pos;
  logic [TOTAL_MSB:0]  r_total;
  logic                r_wr_en;
  logic [2:0]          r_len;
  logic [1:0]          r_off;
  logic                r_pad80;
  logic                r_padz;
  logic                r_addtot;
  logic                r_block_done;

  logic       w_beat;
  logic       w_wr;
  logic       w_p80;
  logic       w_pz;
  logic       w_at;
  logic [2:0] w_len;
  logic [1:0] w_off;
  logic [2:0] w_room;
  logic [2:0] w_rd_len;
  logic [2:0] w_pad80_len;
  logic [6:0] w_pos_sum;
  logic [5:0] w_pos_next;
  logic       w_accept;

  assign w_room      = r_first ? (3'd4 - {1'b0, r_addr[1:0]}) : 3'd4;
  assign w_rd_len    = ({2'b00, w_room} < r_rem) ? w_room : r_rem[2:0];
  assign w_pad80_len = 3'd4 - {1'b0, r_pos[1:0]};

  always_comb begin
    w_beat = 1'b0;
    w_wr   = 1'b0;
    w_p80  = 1'b0;
    w_pz   = 1'b0;
    w_at   = 1'b0;
    w_len  = 3'd0;
    w_off  = 2'd0;
    if (!stall) begin
      case (r_state)
        S_RD: begin
          w_beat = 1'b1;
          w_wr   = 1'b1;
          w_len  = w_rd_len;
          w_off  = r_first ? r_addr[1:0] : 2'd0;
        end
        S_PAD80: begin
          w_beat = 1'b1;
          w_p80  = 1'b1;
          w_pz   = 1'b1;
          w_len  = w_pad80_len;
        end
        S_PADZ, S_LENHI: begin
          w_beat = 1'b1;
          w_pz   = 1'b1;
          w_len  = 3'd4;
        end
        S_LENLO: begin
          w_beat = 1'b1;
          w_at   = 1'b1;
          w_len  = 3'd4;
        end
        default: ;
      endcase
    end
  end

  // Bit 6 of the sum marks the beat that completes the 64-byte block.
  assign w_pos_sum  = {1'b0, r_pos} + {4'b0000, w_len};
  assign w_pos_next = w_pos_sum[5:0];

`ifdef SHA256_FEED_ERR_CHK_EN
  logic          r_err;
  logic          w_req_bad;
  logic [1:0]    w_eff_pos_lo;
  logic [TW:0]   w_tot_sum;

  assign w_eff_pos_lo = new_ctx ? 2'd0 : r_pos[1:0];
  assign w_req_bad    = (byte_cnt == 5'd0) || (byte_cnt > 5'd16) ||
                        ((start_addr[1:0] != 2'd0) && (w_eff_pos_lo != 2'd0));
  assign w_accept     = start && ready && !w_req_bad;
  assign w_tot_sum    = {1'b0, r_total} + (TW+1)'(w_len);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_err <= 1'b0;
    end else if ((start && !ready) || (start && ready && w_req_bad) ||
                 (w_wr && w_tot_sum[TW])) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_accept = start && ready;
  assign err      = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_rem        <= 5'd0;
      r_first      <= 1'b0;
      r_finish     <= 1'b0;
      r_pos        <= 6'd0;
      r_total      <= '0;
      r_wr_en      <= 1'b0;
      r_len        <= 3'd0;
      r_off        <= 2'd0;
      r_pad80      <= 1'b0;
      r_padz       <= 1'b0;
      r_addtot     <= 1'b0;
      r_block_done <= 1'b0;
    end else begin
      r_wr_en      <= w_wr;
      r_len        <= w_len;
      r_off        <= w_off;
      r_pad80      <= w_p80;
      r_padz       <= w_pz;
      r_addtot     <= w_at;
      r_block_done <= w_beat && w_pos_sum[6];
      if (w_beat) r_pos <= w_pos_next;
      if (w_wr) r_total <= r_total + TW'(w_len);

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr   <= start_addr;
            r_rem    <= byte_cnt;
            r_first  <= 1'b1;
            r_finish <= finish;
            if (new_ctx) begin
              r_pos   <= 6'd0;
              r_total <= '0;
            end
            // A zero-length request is a pure finish: go straight to padding.
            if (byte_cnt == 5'd0) r_state <= finish ? S_PAD80 : S_IDLE;
            else                  r_state <= S_RD;
          end
        end
        S_RD: begin
          if (!stall) begin
            r_addr  <= r_addr + AW'(w_len);
            r_rem   <= r_rem - {2'b00, w_len};
            r_first <= 1'b0;
            if ({2'b00, w_len} == r_rem) r_state <= r_finish ? S_PAD80 : S_IDLE;
          end
        end
        S_PAD80: if (!stall) r_state <= (w_pos_next == 6'd56) ? S_LENHI : S_PADZ;
        S_PADZ:  if (!stall && (w_pos_next == 6'd56)) r_state <= S_LENHI;
        S_LENHI: if (!stall) r_state <= S_LENLO;
        S_LENLO: if (!stall) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready       = (r_state == S_IDLE);
  assign mem_rd_en   = w_wr;
  assign mem_rd_addr = r_addr[ADDR_MSB+2:2];
  assign wr_en       = r_wr_en;
  assign len         = r_len;
  assign off         = r_off;
  assign add0x80pad  = r_pad80;
  assign add0pad     = r_padz;
  assign add_total   = r_addtot;
  assign total       = r_total;
  assign block_done  = r_block_done;

endmodule

// File: tb/tb_sha256_bytes_feed.sv
// Scoreboard bench for sha256_bytes_feed: directed requests push expected reads and beats; a monitor checks them.
module tb_sha256_bytes_feed;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  start_addr = '0;
  logic [4:0]  byte_cnt = '0;
  logic        new_ctx = 1'b0;
  logic        finish = 1'b0;
  logic        stall = 1'b0;
  logic        ready, mem_rd_en, wr_en, add0x80pad, add0pad, add_total, block_done, err;
  logic [7:0]  mem_rd_addr;
  logic [2:0]  len;
  logic [1:0]  off;
  logic [11:0] total;

  sha256_bytes_feed dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .start_addr(start_addr), .byte_cnt(byte_cnt),
    .new_ctx(new_ctx), .finish(finish), .stall(stall), .ready(ready), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .wr_en(wr_en), .len(len), .off(off), .add0x80pad(add0x80pad),
    .add0pad(add0pad), .add_total(add_total), .total(total), .block_done(block_done), .err(err)
  );

  always #5 CLK = ~CLK;

  // Beat word: {wr_en, add0x80pad, add0pad, add_total, len, off, block_done, total-if-length-beat}
  logic [21:0] exp_q[$];
  logic [7:0]  addr_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int beat_cnt = 0;
  int rd_cnt = 0;
  int bd_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [21:0] mk(input logic wr, input logic p80, input logic pz, input logic at,
                                     input logic [2:0] l, input logic [1:0] o, input logic bd,
                                     input logic [11:0] tot);
    return {wr, p80, pz, at, l, o, bd, tot};
  endfunction

  task automatic push_data(input logic [2:0] l, input logic [1:0] o, input logic bd);
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, l, o, bd, 12'd0));
  endtask
  task automatic push_pad80(input logic [2:0] l, input logic bd);
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, l, 2'd0, bd, 12'd0));
  endtask
  task automatic push_padz(input logic bd);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 2'd0, bd, 12'd0));
  endtask
  task automatic push_len(input logic [11:0] tot, input logic bd);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 2'd0, bd, tot));
  endtask
  task automatic push_reads(input int first, input int n);
    for (int i = 0; i < n; i++) addr_q.push_back(8'(first + i));
  endtask

  always @(negedge CLK) begin
    if (RST_N) begin
      if (mem_rd_en) begin
        rd_cnt++;
        if (addr_q.size() == 0) fail("unexpected_read");
        else check("rd_addr", {24'd0, mem_rd_addr}, {24'd0, addr_q.pop_front()});
      end
      if (block_done) bd_cnt++;
      if (wr_en || add0pad || add_total) begin
        logic [21:0] act;
        beat_cnt++;
        act = {wr_en, add0x80pad, add0pad, add_total, len, off, block_done,
               add_total ? total : 12'd0};
        if (exp_q.size() == 0) fail("unexpected_beat");
        else check("beat", {10'd0, act}, {10'd0, exp_q.pop_front()});
      end else if (block_done) begin
        fail("block_done_without_beat");
      end
    end
  end

  task automatic req(input logic [9:0] a, input logic [4:0] c, input logic nc, input logic fin);
    int k;
    k = 0;
    while (!ready && k < 500) begin
      @(posedge CLK); #1;
      k++;
    end
    if (!ready) fail("ready_timeout");
    start_addr = a; byte_cnt = c; new_ctx = nc; finish = fin; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; new_ctx = 1'b0; finish = 1'b0;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || addr_q.size() != 0 || !ready) && k < 1000) begin
      @(posedge CLK); #1;
      k++;
    end
    @(posedge CLK); #1;
    check({nm, "_pending"}, exp_q.size() + addr_q.size(), 0);
    check({nm, "_ready"}, {31'd0, ready}, 1);
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, "_ready"}, {31'd0, ready}, 1);
    check({nm, "_strobes"}, {26'd0, mem_rd_en, wr_en, add0x80pad, add0pad, add_total, block_done}, 0);
    check({nm, "_len_off"}, {27'd0, len, off}, 0);
    check({nm, "_total"}, {20'd0, total}, 0);
    check({nm, "_err"}, {31'd0, err}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int b0, r0, d0;
    @(negedge CLK);
    check_idle_outputs("reset");
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Aligned 8 bytes, new context
    push_reads(0, 2); push_data(4, 0, 0); push_data(4, 0, 0);
    req(10'h000, 5'd8, 1'b1, 1'b0);
    drain("t1");
    check("t1_total", {20'd0, total}, 8);

    // Unaligned start: head byte, full word, tail byte
    push_reads(0, 3); push_data(1, 3, 0); push_data(4, 0, 0); push_data(1, 0, 0);
    req(10'h003, 5'd6, 1'b1, 1'b0);
    drain("t2");
    check("t2_total", {20'd0, total}, 6);

    // pos=8 then a data-less finish
    push_reads(4, 2); push_data(4, 0, 0); push_data(4, 0, 0);
    req(10'h010, 5'd8, 1'b1, 1'b0);
    drain("t3a");
    b0 = beat_cnt; d0 = bd_cnt;
    push_pad80(4, 0);
    for (int i = 0; i < 11; i++) push_padz(0);
    push_padz(0);
    push_len(12'd8, 1);
    req(10'h000, 5'd0, 1'b0, 1'b1);
    drain("t3b");
    check("t3_beats", beat_cnt - b0, 14);
    check("t3_block_done", bd_cnt - d0, 1);

    // Fill to pos=57 with finish on the last request: padding spills into a second block
    b0 = beat_cnt; d0 = bd_cnt;
    for (int r = 0; r < 3; r++) begin
      push_reads(0, 4);
      for (int i = 0; i < 4; i++) push_data(4, 0, 0);
      req(10'h000, 5'd16, (r == 0), 1'b0);
    end
    push_reads(8, 3); push_data(4, 0, 0); push_data(4, 0, 0); push_data(1, 0, 0);
    push_pad80(3, 0);
    push_padz(1);
    for (int i = 0; i < 14; i++) push_padz(0);
    push_padz(0);
    push_len(12'd57, 1);
    req(10'h020, 5'd9, 1'b0, 1'b1);
    drain("t4");
    check("t4_beats", beat_cnt - b0, 33);
    check("t4_block_done", bd_cnt - d0, 2);

    // Stall for 5 cycles in the middle of a read run
    push_reads(16, 4);
    for (int i = 0; i < 4; i++) push_data(4, 0, 0);
    req(10'h040, 5'd16, 1'b1, 1'b0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    stall = 1'b1;
    b0 = beat_cnt; r0 = rd_cnt;
    repeat (5) @(posedge CLK);
    #1;
    check("stall_beats_le1", {31'd0, (beat_cnt - b0) <= 1}, 1);
    check("stall_reads", rd_cnt - r0, 0);
    stall = 1'b0;
    drain("t5");
    check("t5_total", {20'd0, total}, 16);

    // start while busy is ignored
    push_reads(0, 4);
    for (int i = 0; i < 4; i++) push_data(4, 0, 0);
    req(10'h000, 5'd16, 1'b1, 1'b0);
    start_addr = 10'h080; byte_cnt = 5'd4; new_ctx = 1'b1; finish = 1'b1; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; new_ctx = 1'b0; finish = 1'b0;
    drain("t6");
    check("t6_total", {20'd0, total}, 16);
`ifdef SHA256_FEED_ERR_CHK_EN
    check("t6_err", {31'd0, err}, 1);
`else
    check("t6_err", {31'd0, err}, 0);
`endif

    // Reset mid-transfer
    push_reads(0, 4);
    for (int i = 0; i < 4; i++) push_data(4, 0, 0);
    req(10'h000, 5'd16, 1'b1, 1'b1);
    @(posedge CLK); #1;
    RST_N = 1'b0;
    exp_q.delete();
    addr_q.delete();
    #1;
    check_idle_outputs("midreset");
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Post-reset sanity: fresh request with no new_ctx starts from total 0
    push_reads(1, 1); push_data(2, 0, 0);
    req(10'h004, 5'd2, 1'b0, 1'b0);
    drain("t7");
    check("t7_total", {20'd0, total}, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
